piece_controller: RTL and testbench

Active-piece FSM for the Tetris datapath. Holds the falling piece's shape, `left`, `top` and rotation, and accepts gravity ticks and player commands. Drives a candidate position into a shape decoder and tests the four returned cells against the board occupancy map. Commits legal moves and hands landed pieces to the board writer through a valid/ready lock handshake.

---
 rtl/piece_controller.sv | 256 +++++++++++++++++++++++++
 tb/tb_piece_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_controller.sv
// Active-piece controller: holds the falling piece, proposes candidate moves
// to the shape decoder, checks the returned cells against the board and hands
// landed pieces to the board writer.
module piece_controller #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20,
    parameter int unsigned SPAWN_X = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         tick_i,
    input  logic                         move_left_i,
    input  logic                         move_right_i,
    input  logic                         rotate_i,
    input  logic                         drop_i,
    input  logic [2:0]                   next_shape_i,
    input  logic [BOARD_W*BOARD_H-1:0]   board_i,
    input  logic [3:0][4:0]              cell_x_i,
    input  logic [3:0][4:0]              cell_y_i,
    input  logic                         lock_ready_i,
    output logic                         alive_o,
    output logic [2:0]                   shape_o,
    output logic [4:0]                   pos_left_o,
    output logic [4:0]                   pos_top_o,
    output logic [1:0]                   pos_rot_o,
    output logic [4:0]                   cand_left_o,
    output logic [4:0]                   cand_top_o,
    output logic [1:0]                   cand_rot_o,
    output logic                         lock_valid_o,
    output logic                         game_over_o,
    output logic                         busy_o
);

    localparam int unsigned COORD_W = 5;
    localparam int unsigned ROT_W   = 2;
    localparam int unsigned SHAPE_W = 3;
    localparam int unsigned NCELL   = 4;
    localparam int unsigned BOARD_N = BOARD_W * BOARD_H;
    localparam int unsigned IDX_W   = $clog2(BOARD_N);

    localparam logic [COORD_W-1:0] X_LIM      = COORD_W'(BOARD_W);
    localparam logic [COORD_W-1:0] Y_LIM      = COORD_W'(BOARD_H);
    localparam logic [COORD_W-1:0] SPAWN_LEFT = COORD_W'(SPAWN_X);
    localparam logic [SHAPE_W-1:0] SHAPE_BAD  = SHAPE_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_WAIT,
        ST_CHECK,
        ST_LOCK,
        ST_GAMEOVER
    } state_e;

    // What produced the candidate being checked: decides the reaction to a hit.
    typedef enum logic [1:0] {
        ORG_SPAWN,
        ORG_FALL,
        ORG_MOVE
    } origin_e;

    state_e               state_q, state_d;
    origin_e              origin_q, origin_d;
    logic                 drop_q, drop_d;
    logic [SHAPE_W-1:0]   shape_q, shape_d;
    logic [COORD_W-1:0]   pos_left_q, pos_left_d;
    logic [COORD_W-1:0]   pos_top_q, pos_top_d;
    logic [ROT_W-1:0]     pos_rot_q, pos_rot_d;
    logic [COORD_W-1:0]   cand_left_q, cand_left_d;
    logic [COORD_W-1:0]   cand_top_q, cand_top_d;
    logic [ROT_W-1:0]     cand_rot_q, cand_rot_d;
    logic                 alive_q, alive_d;
    logic                 lock_valid_q, lock_valid_d;
    logic                 game_over_q, game_over_d;
    logic                 busy_q, busy_d;

    logic                 hit_c;
    logic [IDX_W-1:0]     idx;

    // Collision test of the decoder's four cells; out-of-range cells never index the board.
    always_comb begin
        hit_c = 1'b0;
        idx   = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (cell_x_i[i] >= X_LIM || cell_y_i[i] >= Y_LIM) begin
                hit_c = 1'b1;
            end else begin
                idx = IDX_W'(cell_y_i[i]) * IDX_W'(BOARD_W) + IDX_W'(cell_x_i[i]);
                if (board_i[idx]) begin
                    hit_c = 1'b1;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            origin_q     <= ORG_SPAWN;
            drop_q       <= 1'b0;
            shape_q      <= '0;
            pos_left_q   <= '0;
            pos_top_q    <= '0;
            pos_rot_q    <= '0;
            cand_left_q  <= '0;
            cand_top_q   <= '0;
            cand_rot_q   <= '0;
            alive_q      <= 1'b0;
            lock_valid_q <= 1'b0;
            game_over_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            origin_q     <= origin_d;
            drop_q       <= drop_d;
            shape_q      <= shape_d;
            pos_left_q   <= pos_left_d;
            pos_top_q    <= pos_top_d;
            pos_rot_q    <= pos_rot_d;
            cand_left_q  <= cand_left_d;
            cand_top_q   <= cand_top_d;
            cand_rot_q   <= cand_rot_d;
            alive_q      <= alive_d;
            lock_valid_q <= lock_valid_d;
            game_over_q  <= game_over_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        origin_d     = origin_q;
        drop_d       = drop_q;
        shape_d      = shape_q;
        pos_left_d   = pos_left_q;
        pos_top_d    = pos_top_q;
        pos_rot_d    = pos_rot_q;
        cand_left_d  = cand_left_q;
        cand_top_d   = cand_top_q;
        cand_rot_d   = cand_rot_q;
        alive_d      = alive_q;
        lock_valid_d = lock_valid_q;
        game_over_d  = game_over_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    game_over_d = 1'b0;
                    state_d     = ST_SPAWN;
                end
            end

            ST_SPAWN: begin
                shape_d     = (next_shape_i == SHAPE_BAD) ? '0 : next_shape_i;
                cand_left_d = SPAWN_LEFT;
                cand_top_d  = '0;
                cand_rot_d  = '0;
                alive_d     = 1'b1;
                drop_d      = 1'b0;
                origin_d    = ORG_SPAWN;
                state_d     = ST_CHECK;
            end

            ST_WAIT: begin
                // One command per cycle; lower-priority pulses are discarded.
                if (drop_i || tick_i || rotate_i || move_left_i || move_right_i) begin
                    cand_left_d = pos_left_q;
                    cand_top_d  = pos_top_q;
                    cand_rot_d  = pos_rot_q;
                    origin_d    = ORG_MOVE;
                    state_d     = ST_CHECK;
                    if (drop_i) begin
                        cand_top_d = pos_top_q + COORD_W'(1);
                        drop_d     = 1'b1;
                        origin_d   = ORG_FALL;
                    end else if (tick_i) begin
                        cand_top_d = pos_top_q + COORD_W'(1);
                        origin_d   = ORG_FALL;
                    end else if (rotate_i) begin
                        cand_rot_d = pos_rot_q + ROT_W'(1);
                    end else if (move_left_i) begin
                        cand_left_d = pos_left_q - COORD_W'(1);
                    end else begin
                        cand_left_d = pos_left_q + COORD_W'(1);
                    end
                end
            end

            ST_CHECK: begin
                if (!hit_c) begin
                    pos_left_d = cand_left_q;
                    pos_top_d  = cand_top_q;
                    pos_rot_d  = cand_rot_q;
                    if (drop_q) begin
                        cand_top_d = cand_top_q + COORD_W'(1);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    case (origin_q)
                        ORG_SPAWN: begin
                            alive_d     = 1'b0;
                            game_over_d = 1'b1;
                            state_d     = ST_GAMEOVER;
                        end
                        ORG_FALL: begin
                            drop_d       = 1'b0;
                            lock_valid_d = 1'b1;
                            state_d      = ST_LOCK;
                        end
                        default: begin
                            state_d = ST_WAIT;
                        end
                    endcase
                end
            end

            ST_LOCK: begin
                if (lock_valid_q && lock_ready_i) begin
                    lock_valid_d = 1'b0;
                    alive_d      = 1'b0;
                    state_d      = ST_SPAWN;
                end
            end

            ST_GAMEOVER: begin
                if (start_i) begin
                    game_over_d = 1'b0;
                    state_d     = ST_SPAWN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_WAIT);
    end

    assign alive_o      = alive_q;
    assign shape_o      = shape_q;
    assign pos_left_o   = pos_left_q;
    assign pos_top_o    = pos_top_q;
    assign pos_rot_o    = pos_rot_q;
    assign cand_left_o  = cand_left_q;
    assign cand_top_o   = cand_top_q;
    assign cand_rot_o   = cand_rot_q;
    assign lock_valid_o = lock_valid_q;
    assign game_over_o  = game_over_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: random play against a board-level reference
// model, with a scoreboard monitor checking every settled outcome.
module tb_piece_controller;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int SX = 3;
    localparam int N  = W * H;

    localparam int EV_WAIT = 0;
    localparam int EV_LOCK = 1;
    localparam int EV_GO   = 2;

    // Shape cells at rotation 0 inside a 4x4 box; rotation maps (x,y) -> (3-y, x).
    localparam int BX [7][4] = '{'{1,2,0,1}, '{0,1,1,2}, '{0,1,2,1}, '{0,0,0,1},
                                 '{0,1,2,3}, '{1,1,1,0}, '{0,1,0,1}};
    localparam int BY [7][4] = '{'{0,0,1,1}, '{0,0,1,1}, '{0,0,0,1}, '{0,1,2,2},
                                 '{0,0,0,0}, '{0,1,2,2}, '{0,0,1,1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, tick, mv_l, mv_r, rot, drop, lock_ready;
    logic [2:0]       next_shape;
    logic [N-1:0]     board;
    logic [3:0][4:0]  cell_x, cell_y;
    logic             alive, lock_valid, game_over, busy;
    logic [2:0]       shape;
    logic [4:0]       pos_left, pos_top, cand_left, cand_top;
    logic [1:0]       pos_rot, cand_rot;

    typedef struct {
        int kind;
        int left;
        int top;
        int rot;
        int shape;
        int alive;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_left, m_top, m_rot, m_shape;

    always #5 clk = ~clk;

    piece_controller #(.BOARD_W(W), .BOARD_H(H), .SPAWN_X(SX)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .tick_i(tick),
        .move_left_i(mv_l), .move_right_i(mv_r), .rotate_i(rot), .drop_i(drop),
        .next_shape_i(next_shape), .board_i(board), .cell_x_i(cell_x), .cell_y_i(cell_y),
        .lock_ready_i(lock_ready), .alive_o(alive), .shape_o(shape),
        .pos_left_o(pos_left), .pos_top_o(pos_top), .pos_rot_o(pos_rot),
        .cand_left_o(cand_left), .cand_top_o(cand_top), .cand_rot_o(cand_rot),
        .lock_valid_o(lock_valid), .game_over_o(game_over), .busy_o(busy)
    );

    function automatic int off(input int s, input int r, input int i, input bit want_y);
        int dx, dy, t, ss;
        ss = (s > 6) ? 0 : s;
        dx = BX[ss][i];
        dy = BY[ss][i];
        for (int k = 0; k < r; k++) begin
            t  = dx;
            dx = 3 - dy;
            dy = t;
        end
        return want_y ? dy : dx;
    endfunction

    function automatic logic [4:0] sat5(input int v);
        return (v > 31) ? 5'd31 : 5'(v);
    endfunction

    // Shape decoder stand-in: absolute cell coordinates, saturated at 31.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cell_x[i] = sat5(int'(cand_left) + off(int'(shape), int'(cand_rot), i, 1'b0));
            cell_y[i] = sat5(int'(cand_top) + off(int'(shape), int'(cand_rot), i, 1'b1));
        end
    end

    // Reference legality of a placement; left may be 31 after a wrapped move.
    function automatic bit fits(input int s, input int l, input int t, input int r);
        int x, y;
        for (int i = 0; i < 4; i++) begin
            x = l + off(s, r, i, 1'b0);
            y = t + off(s, r, i, 1'b1);
            if (x >= W || y >= H) return 1'b0;
            if (board[8'(y * W + x)]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind);
        exp_t e;
        e.kind  = kind;
        e.left  = m_left;
        e.top   = m_top;
        e.rot   = m_rot;
        e.shape = m_shape;
        e.alive = (kind == EV_GO) ? 0 : 1;
        q.push_back(e);
    endtask

    // Monitor: every settled outcome (WAIT entry, LOCK entry, game over) pops one expectation.
    initial begin
        bit   pb, plv, pgo;
        exp_t e;
        int   kind;
        pb  = 1'b1;
        plv = 1'b0;
        pgo = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb  = 1'b1;
                plv = 1'b0;
                pgo = 1'b0;
            end else begin
                if ((pb && !busy) || (lock_valid && !plv) || (game_over && !pgo)) begin
                    kind = lock_valid ? EV_LOCK : (game_over ? EV_GO : EV_WAIT);
                    if (q.size() == 0) begin
                        chk("unexpected_event", kind, -1);
                    end else begin
                        e = q.pop_front();
                        chk("ev_kind",  kind,            e.kind);
                        chk("ev_left",  int'(pos_left),  e.left);
                        chk("ev_top",   int'(pos_top),   e.top);
                        chk("ev_rot",   int'(pos_rot),   e.rot);
                        chk("ev_shape", int'(shape),     e.shape);
                        chk("ev_alive", int'(alive),     e.alive);
                    end
                end
                pb  = busy;
                plv = lock_valid;
                pgo = game_over;
            end
        end
    end

    task automatic clear_pulses();
        start = 1'b0; tick = 1'b0; mv_l = 1'b0; mv_r = 1'b0; rot = 1'b0; drop = 1'b0;
    endtask

    // Caller has raised start or lock_ready at a negedge; this runs the spawn.
    task automatic spawn(input int ns);
        int s;
        bit ok;
        s          = (ns == 7) ? 0 : ns;
        next_shape = 3'(ns);
        m_shape    = s;
        ok         = fits(s, SX, 0, 0);
        if (ok) begin
            m_left = SX; m_top = 0; m_rot = 0;
            push(EV_WAIT);
        end else begin
            push(EV_GO);
        end
        @(negedge clk);
        start      = 1'b0;
        lock_ready = 1'b0;
        chk("spawn_game_over", int'(game_over), 0);
        chk("spawn_alive", int'(alive), 0);
        chk("spawn_lock_valid", int'(lock_valid), 0);
        chk("spawn_busy", int'(busy), 1);
        @(negedge clk);
        chk("spawn_cand_left", int'(cand_left), SX);
        chk("spawn_cand_top", int'(cand_top), 0);
        chk("spawn_cand_rot", int'(cand_rot), 0);
        chk("spawn_shape", int'(shape), s);
        chk("check_alive", int'(alive), 1);
        @(negedge clk);
        if (ok) chk("spawn_to_wait_busy", int'(busy), 0);
        else    chk("spawn_to_gameover", int'(game_over), 1);
    endtask

    task automatic do_start(input int ns);
        start = 1'b1;
        spawn(ns);
    endtask

    task automatic accept(input int hold, input int ns);
        for (int h = 0; h < hold; h++) begin
            chk("lock_hold_valid", int'(lock_valid), 1);
            chk("lock_hold_alive", int'(alive), 1);
            chk("lock_hold_top", int'(pos_top), m_top);
            chk("lock_hold_left", int'(pos_left), m_left);
            @(negedge clk);
        end
        lock_ready = 1'b1;
        spawn(ns);
    endtask

    task automatic cmd(input bit d, input bit t, input bit ro, input bit l, input bit r);
        int cl, ct, cr, k, top0, jexp, j, kind, ol, ot, orr;
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        if (busy) chk("wait_timeout", 1, 0);
        if (!(d || t || ro || l || r)) begin
            @(negedge clk);
            chk("no_cmd_stays_wait", int'(busy), 0);
            return;
        end
        cl = m_left; ct = m_top; cr = m_rot;
        ol = m_left; ot = m_top; orr = m_rot;
        if (d || t)   ct = m_top + 1;
        else if (ro)  cr = (m_rot + 1) % 4;
        else if (l)   cl = (m_left + 31) % 32;
        else          cl = (m_left + 1) % 32;
        top0 = m_top;
        k    = 0;
        if (d) begin
            while (fits(m_shape, m_left, m_top + 1, m_rot)) begin
                m_top++;
                k++;
            end
            kind = EV_LOCK;
            jexp = k + 2;
        end else if (t) begin
            if (fits(m_shape, m_left, m_top + 1, m_rot)) begin
                m_top++;
                kind = EV_WAIT;
            end else begin
                kind = EV_LOCK;
            end
            jexp = 2;
        end else begin
            if (fits(m_shape, cl, ct, cr)) begin
                m_left = cl; m_top = ct; m_rot = cr;
            end
            kind = EV_WAIT;
            jexp = 2;
        end
        push(kind);
        drop = d; tick = t; rot = ro; mv_l = l; mv_r = r;
        @(negedge clk);
        clear_pulses();
        chk("cand_left", int'(cand_left), cl);
        chk("cand_top", int'(cand_top), ct);
        chk("cand_rot", int'(cand_rot), cr);
        if (!d) begin
            chk("pos_left_not_yet", int'(pos_left), ol);
            chk("pos_top_not_yet", int'(pos_top), ot);
            chk("pos_rot_not_yet", int'(pos_rot), orr);
        end
        j = 1;
        while (busy && !lock_valid && !game_over && j < 60) begin
            if (d) chk("drop_row", int'(pos_top), top0 + j - 1);
            @(negedge clk);
            j++;
        end
        chk("settle_cycle", j, jexp);
    endtask

    initial begin
        rst_n      = 1'b0;
        lock_ready = 1'b0;
        next_shape = 3'd0;
        board      = '0;
        clear_pulses();
        m_left = 0; m_top = 0; m_rot = 0; m_shape = 0;
        repeat (3) @(negedge clk);
        chk("rst_alive", int'(alive), 0);
        chk("rst_lock_valid", int'(lock_valid), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_pos", int'({shape, pos_left, pos_top, pos_rot}), 0);
        chk("rst_cand", int'({cand_left, cand_top, cand_rot}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_holds", int'(busy), 1);

        // Directed: square spawn, priority, left wrap, drops.
        do_start(6);
        cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        accept(5, 4);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        accept(2, 7);

        // Random play on a board with a rough floor.
        for (int i = 0; i < N; i++) begin
            if (i >= 12 * W) board[8'(i)] = ($urandom_range(0, 2) == 0);
        end
        for (int n = 0; n < 200; n++) begin
            cmd($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0);
            if (lock_valid) accept(int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
            if (game_over) do_start(int'($urandom_range(0, 7)));
        end

        // Spawn collision and the ignored-command window.
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        board = {{(N - 2 * W){1'b0}}, {(2 * W){1'b1}}};
        accept(1, int'($urandom_range(0, 7)));
        for (int n = 0; n < 3; n++) begin
            drop = 1'b1; tick = 1'b1; rot = 1'b1; mv_l = 1'b1; mv_r = 1'b1;
            @(negedge clk);
            clear_pulses();
            chk("go_held", int'(game_over), 1);
            chk("go_busy", int'(busy), 1);
            chk("go_alive", int'(alive), 0);
            chk("go_pos_top", int'(pos_top), m_top);
        end
        board = '0;
        do_start(int'($urandom_range(0, 7)));

        // Reset in the middle of a lock.
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_lock", int'(lock_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_drops_lock_valid", int'(lock_valid), 0);
        chk("reset_drops_alive", int'(alive), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_left = 0; m_top = 0; m_rot = 0;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", int'(busy), 1);
        chk("post_reset_alive", int'(alive), 0);
        chk("post_reset_pos_top", int'(pos_top), 0);

        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
